// File: rtl/hist_lut_gen.sv
// Histogram + CDF based LUT generator for histogram equalisation: counts one
// frame of 8-bit pixels, then emits a 256-entry 0..255 remap table.
module hist_lut_gen #(
    parameter int CNTW = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sink_data,
    input  logic       sink_valid,
    input  logic       sink_eop,
    output logic [7:0] update_address,
    output logic [7:0] update_data,
    output logic       update,
    output logic       busy,
    output logic       lut_done
);

    localparam int NW = CNTW + 8;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {INIT, ACCUM, FLUSH, CALC} state_t;

    state_t            state;
    logic [7:0]        init_cnt;
    logic [7:0]        bin_k;
    logic [3:0]        cyc;
    logic              flush_cnt;
    logic [CNTW-1:0]   total;
    logic [CNTW-1:0]   cdf;
    logic [NW-1:0]     num;
    logic [7:0]        quo;

    logic [CNTW-1:0]   mem [0:255];
    logic [CNTW-1:0]   rd_data;
    logic [7:0]        rd_addr;
    logic              wr_en;
    logic [7:0]        wr_addr;
    logic [CNTW-1:0]   wr_data;

    logic              accept;
    logic              vld_p1;
    logic [7:0]        addr_p1;
    logic              vld_p2;
    logic [7:0]        addr_p2;
    logic [CNTW-1:0]   data_p2;

    logic [CNTW-1:0]   bin_base;
    logic [CNTW-1:0]   bin_inc;
    logic [CNTW-1:0]   cdf_new;
    logic [NW-1:0]     num_init;
    logic [2:0]        step_sh;
    logic [NW-1:0]     dvs;
    logic              div_ge;
    logic [NW-1:0]     num_nxt;
    logic [7:0]        quo_nxt;

    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a,
                                                input logic [CNTW-1:0] b);
        logic [CNTW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNTW] ? CNT_MAX : s[CNTW-1:0];
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] a);
        return sat_add(a, CNTW'(1));
    endfunction

    assign accept  = sink_valid && (state == ACCUM);
    assign rd_addr = (state == CALC) ? bin_k : sink_data;

    // The read issued on the same edge as the previous write sees stale data,
    // so a one-deep record of the last write is forwarded into the increment.
    assign bin_base = (vld_p2 && (addr_p2 == addr_p1)) ? data_p2 : rd_data;
    assign bin_inc  = sat_inc(bin_base);

    assign cdf_new  = sat_add(cdf, rd_data);
    assign num_init = (NW'(cdf_new) << 8) - NW'(cdf_new);

    always_comb begin
        step_sh = 3'(4'd9 - cyc);
        dvs     = NW'(total) << step_sh;
        div_ge  = (num >= dvs);
        num_nxt = div_ge ? (num - dvs) : num;
        quo_nxt = quo;
        quo_nxt[step_sh] = div_ge;
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr_p1;
        wr_data = bin_inc;
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_addr = init_cnt;
            wr_data = '0;
        end else if (vld_p1) begin
            wr_en   = 1'b1;
            wr_addr = addr_p1;
            wr_data = bin_inc;
        end else if ((state == CALC) && (cyc == 4'd1)) begin
            wr_en   = 1'b1;
            wr_addr = bin_k;
            wr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= INIT;
            init_cnt       <= '0;
            bin_k          <= '0;
            cyc            <= '0;
            flush_cnt      <= 1'b0;
            total          <= '0;
            cdf            <= '0;
            num            <= '0;
            quo            <= '0;
            vld_p1         <= 1'b0;
            addr_p1        <= '0;
            vld_p2         <= 1'b0;
            addr_p2        <= '0;
            data_p2        <= '0;
            update_address <= '0;
            update_data    <= '0;
            update         <= 1'b0;
            busy           <= 1'b1;
            lut_done       <= 1'b0;
        end else begin
            update   <= 1'b0;
            lut_done <= 1'b0;
            // p0 -> p1: read issued, beat waits for bin data
            vld_p1   <= accept;
            addr_p1  <= sink_data;
            // p1 -> p2: remember the write just committed for forwarding
            vld_p2   <= wr_en;
            addr_p2  <= wr_addr;
            data_p2  <= wr_data;

            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 8'd1;
                    if (init_cnt == 8'd255) begin
                        state <= ACCUM;
                        busy  <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        total <= sat_inc(total);
                        if (sink_eop) begin
                            state     <= FLUSH;
                            flush_cnt <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        bin_k <= '0;
                        cyc   <= '0;
                    end
                end
                CALC: begin
                    cyc <= cyc + 4'd1;
                    if (cyc == 4'd1) begin
                        cdf <= cdf_new;
                        num <= num_init;
                        quo <= '0;
                    end else if ((cyc >= 4'd2) && (cyc <= 4'd9)) begin
                        num <= num_nxt;
                        quo <= quo_nxt;
                        if (cyc == 4'd9) begin
                            update         <= 1'b1;
                            update_address <= bin_k;
                            update_data    <= (total == '0) ? bin_k : quo_nxt;
                        end
                    end else if (cyc == 4'd10) begin
                        cyc   <= '0;
                        bin_k <= bin_k + 8'd1;
                        if (bin_k == 8'd255) begin
                            lut_done <= 1'b1;
                            state    <= ACCUM;
                            busy     <= 1'b0;
                            total    <= '0;
                            cdf      <= '0;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_hist_lut_gen.sv
// Scoreboard bench for hist_lut_gen: a reference histogram/CDF model pushes the
// expected table when a frame is driven; the monitor pops on every update.
module tb_hist_lut_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] sink_data = '0;
    logic       sink_valid = 1'b0;
    logic       sink_eop = 1'b0;
    logic [7:0] update_address;
    logic [7:0] update_data;
    logic       update;
    logic       busy;
    logic       lut_done;

    hist_lut_gen #(.CNTW(22)) dut (
        .clk(clk), .rst(rst),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_eop(sink_eop),
        .update_address(update_address), .update_data(update_data),
        .update(update), .busy(busy), .lut_done(lut_done)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_pass = 0;
    logic [15:0] exp_q[$];
    int pix_q[$];
    int hist[256];
    int eop_cyc = 0;
    int first_upd_cyc = -1;
    int last_upd_cyc = -1;
    int last_upd_addr = -1;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && update) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_update addr=%0d data=%0d", update_address, update_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({update_address, update_data} !== e)
                    $display("FAIL table_entry got addr=%0d data=%0d, want addr=%0d data=%0d",
                             update_address, update_data, e[15:8], e[7:0]);
                else
                    n_pass++;
            end
            if (update_address == 8'd0) begin
                first_upd_cyc = cycle;
            end else begin
                n_checks++;
                if (cycle - last_upd_cyc !== 11)
                    $display("FAIL update_spacing addr=%0d got %0d cycles, want 11",
                             update_address, cycle - last_upd_cyc);
                else
                    n_pass++;
            end
            last_upd_cyc  = cycle;
            last_upd_addr = update_address;
        end
        if (!rst && lut_done) begin
            n_checks++;
            if (last_upd_addr !== 255 || cycle - last_upd_cyc !== 1)
                $display("FAIL lut_done_timing last_addr=%0d delay=%0d, want 255 and 1",
                         last_upd_addr, cycle - last_upd_cyc);
            else
                n_pass++;
        end
    end

    function automatic void push_table();
        longint tot = 0;
        longint cdf = 0;
        longint q;
        for (int k = 0; k < 256; k++) tot += hist[k];
        for (int k = 0; k < 256; k++) begin
            cdf += hist[k];
            q = (tot == 0) ? k : (cdf * 255) / tot;
            exp_q.push_back({8'(k), 8'(q)});
        end
    endfunction

    task automatic drive_frame(input bit gaps, input bit push);
        for (int k = 0; k < 256; k++) hist[k] = 0;
        if (push) first_upd_cyc = -1;
        foreach (pix_q[i]) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                    sink_valid = 1'b0;
                    sink_eop   = 1'b0;
                end
            end
            @(posedge clk); #1;
            sink_valid = 1'b1;
            sink_data  = 8'(pix_q[i]);
            sink_eop   = (i == pix_q.size() - 1);
            hist[pix_q[i]]++;
            if (sink_eop && push) eop_cyc = cycle;
        end
        if (push) push_table();
        @(posedge clk); #1;
        sink_valid = 1'b0;
        sink_eop   = 1'b0;
    endtask

    task automatic wait_lut_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (lut_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int busy_cnt;
        int upd_cnt;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy got %b want 1", busy); else n_pass++;
        n_checks++; if (update !== 1'b0) $display("FAIL reset_update got %b want 0", update); else n_pass++;
        n_checks++; if (lut_done !== 1'b0) $display("FAIL reset_lut_done got %b want 0", lut_done); else n_pass++;
        n_checks++; if (update_address !== 8'd0) $display("FAIL reset_addr got %0d want 0", update_address); else n_pass++;
        n_checks++; if (update_data !== 8'd0) $display("FAIL reset_data got %0d want 0", update_data); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        busy_cnt = 0;
        upd_cnt  = 0;
        @(negedge clk);
        while (busy && busy_cnt < 1000) begin
            busy_cnt++;
            if (update) upd_cnt++;
            @(negedge clk);
        end
        n_checks++; if (busy_cnt !== 256) $display("FAIL init_busy_cycles got %0d want 256", busy_cnt); else n_pass++;
        n_checks++; if (upd_cnt !== 0) $display("FAIL init_update_count got %0d want 0", upd_cnt); else n_pass++;
    endtask

    task automatic check_table_end(input string name);
        bit ok;
        wait_lut_done(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL %s_lut_done got timeout want pulse", name); else n_pass++;
        n_checks++;
        if (first_upd_cyc - eop_cyc !== 13)
            $display("FAIL %s_first_latency got %0d want 13", name, first_upd_cyc - eop_cyc);
        else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL %s_left_in_queue got %0d want 0", name, exp_q.size()); else n_pass++;
    endtask

    task automatic test_ramp();
        pix_q.delete();
        for (int k = 0; k < 256; k++) pix_q.push_back(k);
        drive_frame(1'b0, 1'b1);
        check_table_end("ramp");
    endtask

    task automatic test_constant();
        for (int f = 0; f < 2; f++) begin
            pix_q.delete();
            for (int i = 0; i < 100; i++) pix_q.push_back(50);
            drive_frame(1'b0, 1'b1);
            check_table_end("constant");
        end
    endtask

    task automatic test_rmw_hazard();
        pix_q.delete();
        pix_q.push_back(10); pix_q.push_back(10); pix_q.push_back(10); pix_q.push_back(200);
        drive_frame(1'b0, 1'b1);
        check_table_end("rmw");
    endtask

    task automatic test_busy_drop();
        bit seen;
        pix_q.delete();
        for (int i = 0; i < 64; i++) pix_q.push_back(200);
        drive_frame(1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL busy_drop_calc_busy got 0 want 1"); else n_pass++;
        pix_q.delete();
        for (int k = 0; k < 256; k++) pix_q.push_back(k);
        drive_frame(1'b0, 1'b0);
        check_table_end("busy_drop");
        pix_q.delete();
        for (int i = 0; i < 500; i++) begin
            if (i > 0 && $urandom_range(0, 2) == 0) pix_q.push_back(pix_q[i-1]);
            else pix_q.push_back(int'($urandom_range(0, 255)));
        end
        drive_frame(1'b1, 1'b1);
        check_table_end("after_busy");
    endtask

    task automatic test_reset_mid_calc();
        bit found;
        int busy_cnt;
        pix_q.delete();
        for (int i = 0; i < 30; i++) pix_q.push_back(int'($urandom_range(0, 255)));
        drive_frame(1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (update && update_address == 8'd100) found = 1'b1;
        end
        n_checks++; if (found !== 1'b1) $display("FAIL midcalc_reach_bin100 got timeout want update"); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (update !== 1'b0) $display("FAIL midcalc_update_stop got %b want 0", update); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL midcalc_busy got %b want 1", busy); else n_pass++;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        busy_cnt = 0;
        @(negedge clk);
        while (busy && busy_cnt < 1000) begin
            busy_cnt++;
            @(negedge clk);
        end
        n_checks++; if (busy_cnt !== 256) $display("FAIL midcalc_init_cycles got %0d want 256", busy_cnt); else n_pass++;
        pix_q.delete();
        for (int k = 0; k < 256; k++) pix_q.push_back(k);
        drive_frame(1'b0, 1'b1);
        check_table_end("after_reset");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_constant();
        test_rmw_hazard();
        test_busy_drop();
        test_reset_mid_calc();
        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hist_lut_gen.md
Name: hist_lut_gen

Overview:
- Upstream stage of the histogram-equalisation remapper; both blocks watch the same pixel stream.
- Accumulates a 256-bin histogram of each 8-bit frame.
- After end-of-frame, walks the bins and builds the cumulative distribution. Each bin is scaled to a 0..255 output level with an exact serial divider.
- Emits the mapping table as an update_address/update_data/update write stream, which the remapper loads into its idle LUT bank.

Parameters:
- CNTW, 22, width of bin counters, total-pixel counter and CDF accumulator; supports frames up to 2^CNTW-1 pixels.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- sink_data  input  8  pixel value.
- sink_valid  input  1  pixel qualifier.
- sink_eop  input  1  last pixel of frame; meaningful only when sink_valid=1.
- update_address  output  8  LUT bin index being written.
- update_data  output  8  mapped output level for update_address.
- update  output  1  one-cycle write strobe for update_address/update_data.
- busy  output  1  high in INIT and CALC; pixels are not accumulated while high.
- lut_done  output  1  one-cycle pulse after the 256th update of a table.

Behaviour:
- Reset values: update_address=0, update_data=0, update=0, lut_done=0, busy=1. The state is INIT, and the total counter and CDF accumulator are 0.
- Histogram storage is a 256 x CNTW internal RAM with 1-cycle read latency. Its contents are not reset by rst.
- INIT: write 0 to bins 0..255, one per cycle (256 cycles, busy=1), then go to ACCUM with busy=0. INIT is re-entered on every reset, including a reset mid-CALC.
- ACCUM:
  - Each sink_valid beat performs a read-modify-write increment of bin[sink_data] and increments total.
  - Counts must be exact for any beat pattern, including back-to-back identical values, using forwarding of the in-flight write.
  - Bin and total saturate at 2^CNTW-1.
- sink_valid & sink_eop in ACCUM:
  - The beat is counted as normal.
  - Go to FLUSH for 2 cycles to drain the RMW pipeline, then go to CALC with busy=1.
- CALC: iterate k=0..255, 11 cycles per bin.
  - Cycle 0: read bin[k].
  - Cycle 1: cdf += bin[k], then write 0 to bin[k] (clear-on-read).
  - Cycles 2-9: 8-step restoring division q = floor(cdf*255 / total). The numerator is CNTW+8 bits; since cdf<=total, q<=255 and fits in 8 bits. Step i (7 down to 0): if N >= total<<i then N -= total<<i and q[i]=1.
  - Cycle 10: update=1, update_address=k, update_data=q.
- Timing:
  - The first update is asserted 13 cycles after the eop beat: 2 FLUSH cycles plus 11 cycles for bin 0.
  - Updates are spaced exactly 11 cycles apart; 256 updates take 2816 cycles.
  - update_address and update_data hold their value between strobes.
- total==0: the case is unreachable, since the eop beat is itself counted. The divider still forces q=k (identity) if total==0, as a guard.
- After the update for k=255:
  - Next cycle: lut_done=1.
  - total and cdf are cleared, all bins are already 0, and the state returns to ACCUM with busy=0.
- Pixels arriving while busy=1 are ignored, including eop. The next frame whose first beat arrives in ACCUM is accumulated; a partial frame straddling busy falling is accumulated from that point.
- The pixel input has no backpressure. The CNTW parameter must cover the maximum frame size.

Test Plan:
- Reset, then ACCUM-entry timing: assert and release rst -> busy=1 for exactly 256 cycles, then busy=0. update stays 0 throughout.
- Ramp frame: 256 beats with values 0..255 once each, eop on the last -> first update 13 cycles after eop. For each k, update_data=floor((k+1)*255/256): k=0 gives 0, k=127 gives 127, k=255 gives 255. lut_done comes one cycle after the last update.
- Constant frame: 100 beats of value 50 -> update_data=0 for k<50 and 255 for k>=50. A following identical frame gives identical output, proving clear-on-read.
- RMW hazard: back-to-back beats 10,10,10,200 (eop) -> k<10 gives 0, k=10..199 gives 191, k>=200 gives 255.
- Busy drop: send a full frame during CALC -> no effect on the table in progress. The next frame after lut_done is counted correctly.
- Reset mid-CALC: pulse rst at bin 100 -> update stops immediately and INIT runs. The next frame (the ramp) yields the exact ramp table, with no residue from the aborted frame.
